// File: rtl/char_tokenizer.sv
// ASCII byte stream to token stream (NUM / DASH / COMMA / EOL) with a sticky error flag.
// Optional macro CHAR_TOKENIZER_DIGITS_EN adds o_tok_digits, the digit count of each NUM token.
module char_tokenizer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [7:0]   i_char,
  output logic         o_stall,
  input  logic         i_eof,
  output logic         o_tok_vld,
  output logic [1:0]   o_tok_kind,
  output logic [W-1:0] o_tok_val,
  output logic         o_tok_last,
  input  logic         i_tok_stall,
  output logic         o_error
`ifdef CHAR_TOKENIZER_DIGITS_EN
  ,
  output logic [5:0]   o_tok_digits
`endif
);

  localparam logic [1:0] K_NUM   = 2'd0;
  localparam logic [1:0] K_DASH  = 2'd1;
  localparam logic [1:0] K_COMMA = 2'd2;
  localparam logic [1:0] K_EOL   = 2'd3;

  logic [W-1:0] acc_q, acc_d;
  logic         in_num_q, in_num_d;
  logic         tok_vld_q, tok_vld_d;
  logic [1:0]   tok_kind_q, tok_kind_d;
  logic [W-1:0] tok_val_q, tok_val_d;
  logic         tok_last_q, tok_last_d;
  logic         sep_pend_q, sep_pend_d;
  logic [1:0]   sep_kind_q, sep_kind_d;
  logic         err_q, err_d;
  logic         fin_q, fin_d;
`ifdef CHAR_TOKENIZER_DIGITS_EN
  logic [5:0]   cnt_q, cnt_d;
  logic [5:0]   tok_digits_q, tok_digits_d;
`endif

  logic         tok_free;
  logic         char_acc;
  logic         eof_acc;
  logic         is_digit;
  logic         is_sep;
  logic [1:0]   char_kind;
  logic [W+3:0] acc_x;
  logic [W+3:0] prod;

  // Backpressure comes only from flops plus the downstream stall, never from i_vld/i_char.
  assign o_stall = sep_pend_q | (tok_vld_q & i_tok_stall);

  assign o_tok_vld  = tok_vld_q;
  assign o_tok_kind = tok_kind_q;
  assign o_tok_val  = tok_val_q;
  assign o_tok_last = tok_last_q;
  assign o_error    = err_q;
`ifdef CHAR_TOKENIZER_DIGITS_EN
  assign o_tok_digits = tok_digits_q;
`endif

  assign is_digit  = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign is_sep    = (i_char == 8'h2D) || (i_char == 8'h2C) || (i_char == 8'h0A);
  assign char_kind = (i_char == 8'h2D) ? K_DASH : ((i_char == 8'h2C) ? K_COMMA : K_EOL);
  assign acc_x     = {4'b0000, acc_q};
  assign prod      = (acc_x << 3) + (acc_x << 1) + {{W{1'b0}}, i_char[3:0]};

  always_comb begin
    acc_d      = acc_q;
    in_num_d   = in_num_q;
    tok_vld_d  = tok_vld_q;
    tok_kind_d = tok_kind_q;
    tok_val_d  = tok_val_q;
    tok_last_d = tok_last_q;
    sep_pend_d = sep_pend_q;
    sep_kind_d = sep_kind_q;
    err_d      = err_q;
    fin_d      = fin_q;
`ifdef CHAR_TOKENIZER_DIGITS_EN
    cnt_d        = cnt_q;
    tok_digits_d = tok_digits_q;
`endif

    tok_free = ~tok_vld_q | ~i_tok_stall;
    char_acc = i_vld & ~o_stall & ~fin_q & ~err_q;
    eof_acc  = ~i_vld & ~o_stall & i_eof & ~fin_q & ~err_q;

    if (tok_vld_q && !i_tok_stall) tok_vld_d = 1'b0;

    if (sep_pend_q && tok_free) begin
      tok_vld_d  = 1'b1;
      tok_kind_d = sep_kind_q;
      tok_val_d  = '0;
      tok_last_d = 1'b0;
      sep_pend_d = 1'b0;
`ifdef CHAR_TOKENIZER_DIGITS_EN
      tok_digits_d = 6'd0;
`endif
    end

    if (char_acc) begin
      if (is_digit) begin
        if (|prod[W+3:W]) begin
          err_d = 1'b1;
        end else begin
          acc_d    = prod[W-1:0];
          in_num_d = 1'b1;
`ifdef CHAR_TOKENIZER_DIGITS_EN
          if (cnt_q != 6'h3F) cnt_d = cnt_q + 6'd1;
`endif
        end
      end else if (is_sep) begin
        tok_vld_d  = 1'b1;
        tok_last_d = 1'b0;
        if (in_num_q) begin
          // The number goes out first; the separator waits one acceptance behind it.
          tok_kind_d = K_NUM;
          tok_val_d  = acc_q;
          sep_pend_d = 1'b1;
          sep_kind_d = char_kind;
          acc_d      = '0;
          in_num_d   = 1'b0;
`ifdef CHAR_TOKENIZER_DIGITS_EN
          tok_digits_d = cnt_q;
          cnt_d        = 6'd0;
`endif
        end else begin
          tok_kind_d = char_kind;
          tok_val_d  = '0;
`ifdef CHAR_TOKENIZER_DIGITS_EN
          tok_digits_d = 6'd0;
`endif
        end
      end else if ((i_char != 8'h20) && (i_char != 8'h0D)) begin
        err_d = 1'b1;
      end
    end

    if (eof_acc) begin
      tok_vld_d  = 1'b1;
      tok_kind_d = in_num_q ? K_NUM : K_EOL;
      tok_val_d  = in_num_q ? acc_q : '0;
      tok_last_d = 1'b1;
      fin_d      = 1'b1;
      acc_d      = '0;
      in_num_d   = 1'b0;
`ifdef CHAR_TOKENIZER_DIGITS_EN
      tok_digits_d = in_num_q ? cnt_q : 6'd0;
      cnt_d        = 6'd0;
`endif
    end

    // Error drops whatever is in flight and keeps the slots empty until reset.
    if (err_d) begin
      tok_vld_d  = 1'b0;
      sep_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q      <= '0;
      in_num_q   <= 1'b0;
      tok_vld_q  <= 1'b0;
      tok_kind_q <= K_NUM;
      tok_val_q  <= '0;
      tok_last_q <= 1'b0;
      sep_pend_q <= 1'b0;
      sep_kind_q <= K_NUM;
      err_q      <= 1'b0;
      fin_q      <= 1'b0;
`ifdef CHAR_TOKENIZER_DIGITS_EN
      cnt_q        <= 6'd0;
      tok_digits_q <= 6'd0;
`endif
    end else begin
      acc_q      <= acc_d;
      in_num_q   <= in_num_d;
      tok_vld_q  <= tok_vld_d;
      tok_kind_q <= tok_kind_d;
      tok_val_q  <= tok_val_d;
      tok_last_q <= tok_last_d;
      sep_pend_q <= sep_pend_d;
      sep_kind_q <= sep_kind_d;
      err_q      <= err_d;
      fin_q      <= fin_d;
`ifdef CHAR_TOKENIZER_DIGITS_EN
      cnt_q        <= cnt_d;
      tok_digits_q <= tok_digits_d;
`endif
    end
  end

endmodule

// File: tb/tb_char_tokenizer.sv
// Directed and randomized bench for char_tokenizer; token stream compared against a string-level reference tokenizer.
module tb_char_tokenizer;

  localparam int W  = 64;
  localparam int TW = W + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vld;
  logic [7:0]    i_char;
  logic          o_stall;
  logic          i_eof;
  logic          o_tok_vld;
  logic [1:0]    o_tok_kind;
  logic [W-1:0]  o_tok_val;
  logic          o_tok_last;
  logic          i_tok_stall;
  logic          o_error;
`ifdef CHAR_TOKENIZER_DIGITS_EN
  logic [5:0]    o_tok_digits;
`endif

  logic          bp_rand  = 1'b0;
  logic          bp_force = 1'b0;
  logic          bp_rnd   = 1'b0;
  logic          gap_en   = 1'b0;

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] got_q[$];
  logic [7:0]    stim_q[$];
  logic [7:0]    sym_tab[5] = '{8'h2D, 8'h2C, 8'h0A, 8'h20, 8'h0D};

  int n_checks = 0;
  int n_fail   = 0;

  assign i_tok_stall = bp_rand ? bp_rnd : bp_force;

  char_tokenizer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (i_vld),
    .i_char     (i_char),
    .o_stall    (o_stall),
    .i_eof      (i_eof),
    .o_tok_vld  (o_tok_vld),
    .o_tok_kind (o_tok_kind),
    .o_tok_val  (o_tok_val),
    .o_tok_last (o_tok_last),
    .i_tok_stall(i_tok_stall),
    .o_error    (o_error)
`ifdef CHAR_TOKENIZER_DIGITS_EN
    ,
    .o_tok_digits(o_tok_digits)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bp_rnd = ($urandom_range(0, 2) == 0);
    end
  end

  // Token monitor: a token seen valid and unstalled mid-cycle is accepted at the next edge.
  always @(negedge clk) begin
    if (rst && o_tok_vld && !i_tok_stall)
      got_q.push_back({o_tok_last, o_tok_kind, o_tok_val});
  end

  function automatic logic [TW-1:0] mk(input logic last, input logic [1:0] kind, input logic [W-1:0] val);
    return {last, kind, val};
  endfunction

  // Reference tokenizer over the whole character list.
  function automatic void model_tokens(input bit with_eof);
    logic [W+3:0] cur = '0;
    bit           in  = 0;
    foreach (stim_q[i]) begin
      logic [7:0] c = stim_q[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        cur = cur * 10 + (c - 8'h30);
        in  = 1;
      end else if (c == 8'h2D || c == 8'h2C || c == 8'h0A) begin
        if (in) exp_q.push_back(mk(1'b0, 2'd0, cur[W-1:0]));
        exp_q.push_back(mk(1'b0, (c == 8'h2D) ? 2'd1 : ((c == 8'h2C) ? 2'd2 : 2'd3), '0));
        cur = '0;
        in  = 0;
      end
    end
    if (with_eof) begin
      if (in) exp_q.push_back(mk(1'b1, 2'd0, cur[W-1:0]));
      else    exp_q.push_back(mk(1'b1, 2'd3, '0));
    end
  endfunction

  function automatic void load_str(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endfunction

  // Scoreboard compare
  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_char(input logic [7:0] c);
    int   budget = 0;
    logic taken  = 1'b0;
    logic acc;
    i_vld  = 1'b1;
    i_char = c;
    while (!taken && budget < 300) begin
      @(negedge clk);
      acc = !o_stall;
      @(posedge clk);
      #1;
      if (acc) taken = 1'b1;
      budget++;
    end
    i_vld = 1'b0;
    chk("char_accept", taken, 1'b1);
  endtask

  task automatic send_eof();
    int   budget = 0;
    logic taken  = 1'b0;
    logic acc;
    i_eof = 1'b1;
    while (!taken && budget < 300) begin
      @(negedge clk);
      acc = !o_stall;
      @(posedge clk);
      #1;
      if (acc) taken = 1'b1;
      budget++;
    end
    i_eof = 1'b0;
    chk("eof_accept", taken, 1'b1);
  endtask

  task automatic run_stim();
    foreach (stim_q[i]) begin
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_char(stim_q[i]);
    end
  endtask

  task automatic expect_tokens(input string tag);
    int budget = 0;
    while (got_q.size() < exp_q.size() && budget < 400) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (8) begin @(posedge clk); #1; end
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_tok%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input bit check_outs);
    rst   = 1'b0;
    i_vld = 1'b0;
    i_eof = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (check_outs) begin
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_vld",   o_tok_vld, 1'b0);
      chk("rst_kind",  o_tok_kind, 2'd0);
      chk("rst_val",   o_tok_val, '0);
      chk("rst_last",  o_tok_last, 1'b0);
      chk("rst_error", o_error, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst    = 1'b0;
    i_vld  = 1'b0;
    i_char = 8'h00;
    i_eof  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1);

    // Basic stream, no backpressure
    load_str("12-345,\n");
    run_stim();
    model_tokens(0);
    expect_tokens("basic");
    @(negedge clk);
    chk("basic_error", o_error, 1'b0);
    @(posedge clk);
    #1;

    // Held downstream stall: NUM must stay put and upstream must be stalled
    bp_force = 1'b1;
    load_str("99,");
    run_stim();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_vld",   o_tok_vld, 1'b1);
      chk("hold_tok",   {o_tok_last, o_tok_kind, o_tok_val}, mk(1'b0, 2'd0, 64'd99));
      chk("hold_stall", o_stall, 1'b1);
      @(posedge clk);
      #1;
    end
    bp_force = 1'b0;
    exp_q.push_back(mk(1'b0, 2'd0, 64'd99));
    exp_q.push_back(mk(1'b0, 2'd2, '0));
    load_str("8\n");
    run_stim();
    exp_q.push_back(mk(1'b0, 2'd0, 64'd8));
    exp_q.push_back(mk(1'b0, 2'd3, '0));
    expect_tokens("hold");

    // Largest representable value
    load_str("18446744073709551615,");
    run_stim();
    exp_q.push_back(mk(1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF));
    exp_q.push_back(mk(1'b0, 2'd2, '0));
    expect_tokens("max");

    // One past the largest value
    do_reset(0);
    load_str("18446744073709551616");
    run_stim();
    @(negedge clk);
    chk("ovf_error", o_error, 1'b1);
    chk("ovf_vld",   o_tok_vld, 1'b0);
    @(posedge clk);
    #1;
    load_str(",");
    run_stim();
    expect_tokens("ovf");

    // Illegal byte
    do_reset(0);
    load_str("5x");
    run_stim();
    @(negedge clk);
    chk("ill_error", o_error, 1'b1);
    chk("ill_vld",   o_tok_vld, 1'b0);
    chk("ill_stall", o_stall, 1'b0);
    @(posedge clk);
    #1;
    load_str("3,\n");
    run_stim();
    @(negedge clk);
    chk("ill_stall2", o_stall, 1'b0);
    chk("ill_sticky", o_error, 1'b1);
    @(posedge clk);
    #1;
    expect_tokens("ill");

    // EOF mid-number
    do_reset(0);
    load_str("7");
    run_stim();
    send_eof();
    exp_q.push_back(mk(1'b1, 2'd0, 64'd7));
    expect_tokens("eof_num");

    // EOF after newline
    do_reset(0);
    load_str("\n");
    run_stim();
    send_eof();
    exp_q.push_back(mk(1'b0, 2'd3, '0));
    exp_q.push_back(mk(1'b1, 2'd3, '0));
    expect_tokens("eof_eol");

    // EOF asserted alongside a valid byte is ignored
    do_reset(0);
    i_eof = 1'b1;
    send_char(8'h35);
    i_eof = 1'b0;
    load_str(",");
    run_stim();
    exp_q.push_back(mk(1'b0, 2'd0, 64'd5));
    exp_q.push_back(mk(1'b0, 2'd2, '0));
    expect_tokens("eof_ign");

    // Reset mid-number
    load_str("123");
    run_stim();
    do_reset(1);
    load_str("4,");
    run_stim();
    exp_q.push_back(mk(1'b0, 2'd0, 64'd4));
    exp_q.push_back(mk(1'b0, 2'd2, '0));
    expect_tokens("midrst");

    // Randomized streams with random backpressure and input gaps
    bp_rand = 1'b1;
    gap_en  = 1'b1;
    for (int iter = 0; iter < 20; iter++) begin
      int run = 0;
      do_reset(0);
      stim_q.delete();
      repeat ($urandom_range(8, 30)) begin
        if (run < 15 && $urandom_range(0, 1) == 1) begin
          stim_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
          run++;
        end else begin
          logic [7:0] c = sym_tab[$urandom_range(0, 4)];
          stim_q.push_back(c);
          if (c != 8'h20 && c != 8'h0D) run = 0;
        end
      end
      run_stim();
      send_eof();
      model_tokens(1);
      load_str("1,");
      run_stim();
      expect_tokens($sformatf("rnd%0d", iter));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
